spi_master: RTL and testbench

Memory-mapped SPI master peripheral on the common memory bus, decoded at 0x0006_0000–0x0006_000F alongside the UART, timer and GPIO blocks. The CPU writes bytes into a transmit holding stage. The block shifts each byte out MSB-first in SPI mode 0 and captures the returned byte into a receive register that software polls. Chip select is software-controlled, so multi-byte transactions remain framed.

---
 rtl/spi_master_if.sv | 20 ++
 rtl/spi_master.sv | 218 +++++++++++++++++++++
 tb/tb_spi_master.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// Bus-side port bundle for spi_master: address/strobe/data in, read data and ready out.
interface spi_master_if;
    logic [31:0] address_in;
    logic        sel_in;
    logic        read_in;
    logic [31:0] read_value_out;
    logic [3:0]  write_mask_in;
    logic [31:0] write_value_in;
    logic        ready_out;

    modport master (
        output address_in, sel_in, read_in, write_mask_in, write_value_in,
        input  read_value_out, ready_out
    );

    modport slave (
        input  address_in, sel_in, read_in, write_mask_in, write_value_in,
        output read_value_out, ready_out
    );
endinterface

// File: rtl/spi_master.sv
// Memory-mapped SPI mode-0 master: DATA/STATUS/CTRL registers, MSB-first shifter.
// SPI_MASTER_TXFIFO_EN selects a 4-entry TX FIFO instead of a single holding byte.
module spi_master (
    input  logic             clk,
    input  logic             reset,
    spi_master_if.slave      bus,
    output logic             sclk_out,
    output logic             mosi_out,
    input  logic             miso_in,
    output logic             csn_out
);
    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_HIGH, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [7:0]  hcnt_q, hcnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic [7:0]  div_q, div_d;
    logic        cs_assert_q, cs_assert_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_overrun_q, rx_overrun_d;

    logic [1:0]  reg_sel;
    logic        wr_en, wr_data, wr_status, wr_ctrl, rd_data;
    logic        tx_full, tx_held, tx_pop, tx_push, busy;
    logic [7:0]  tx_head;

    assign reg_sel   = bus.address_in[3:2];
    assign wr_en     = bus.sel_in && bus.write_mask_in[0];
    assign wr_data   = wr_en && (reg_sel == 2'd0);
    assign wr_status = wr_en && (reg_sel == 2'd1);
    assign wr_ctrl   = wr_en && (reg_sel == 2'd2);
    assign rd_data   = bus.sel_in && bus.read_in && (reg_sel == 2'd0);

    assign tx_pop = (state_q == S_IDLE) && tx_held;
    assign busy   = (state_q != S_IDLE) || tx_held;

`ifdef SPI_MASTER_TXFIFO_EN
    logic [3:0][7:0] fifo_q, fifo_d;
    logic [1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [2:0]      count_q, count_d;

    assign tx_full = (count_q == 3'd4);
    assign tx_held = (count_q != 3'd0);
    assign tx_head = fifo_q[rptr_q];
    assign tx_push = wr_data && !tx_full;

    always_comb begin
        fifo_d  = fifo_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (tx_push) begin
            fifo_d[wptr_q] = bus.write_value_in[7:0];
            wptr_d         = wptr_q + 2'd1;
        end
        if (tx_pop) rptr_d = rptr_q + 2'd1;
        if (tx_push && !tx_pop)      count_d = count_q + 3'd1;
        else if (!tx_push && tx_pop) count_d = count_q - 3'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fifo_q  <= '0;
            wptr_q  <= 2'd0;
            rptr_q  <= 2'd0;
            count_q <= 3'd0;
        end else begin
            fifo_q  <= fifo_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end
`else
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       tx_valid_q, tx_valid_d;

    assign tx_full = tx_valid_q;
    assign tx_held = tx_valid_q;
    assign tx_head = tx_byte_q;
    // A write landing on the consume edge refills the register instead of being dropped.
    assign tx_push = wr_data && (!tx_valid_q || tx_pop);

    always_comb begin
        tx_byte_d  = tx_byte_q;
        tx_valid_d = tx_valid_q;
        if (tx_pop) tx_valid_d = 1'b0;
        if (tx_push) begin
            tx_byte_d  = bus.write_value_in[7:0];
            tx_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_byte_q  <= 8'd0;
            tx_valid_q <= 1'b0;
        end else begin
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        hcnt_d       = hcnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        sclk_d       = sclk_q;
        mosi_d       = mosi_q;
        rx_byte_d    = rx_byte_q;
        rx_valid_d   = rd_data ? 1'b0 : rx_valid_q;
        rx_overrun_d = (wr_status && bus.write_value_in[3]) ? 1'b0 : rx_overrun_q;
        div_d        = wr_ctrl ? bus.write_value_in[7:0] : div_q;
        cs_assert_d  = wr_ctrl ? bus.write_value_in[8]   : cs_assert_q;

        unique case (state_q)
            S_IDLE: begin
                sclk_d = 1'b0;
                if (tx_held) begin
                    shift_d   = tx_head;
                    mosi_d    = tx_head[7];
                    bit_cnt_d = 3'd0;
                    hcnt_d    = div_q;
                    state_d   = S_LEAD;
                end
            end
            // The shift happens on the rise together with the MISO sample; the
            // fall only presents the already-shifted MSB, so MOSI moves on the fall.
            S_LEAD: begin
                if (hcnt_q == 8'd0) begin
                    sclk_d  = 1'b1;
                    shift_d = {shift_q[6:0], miso_in};
                    hcnt_d  = div_q;
                    state_d = S_HIGH;
                end else begin
                    hcnt_d = hcnt_q - 8'd1;
                end
            end
            S_HIGH: begin
                if (hcnt_q == 8'd0) begin
                    sclk_d = 1'b0;
                    hcnt_d = div_q;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_DONE;
                    end else begin
                        mosi_d    = shift_q[7];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        state_d   = S_LEAD;
                    end
                end else begin
                    hcnt_d = hcnt_q - 8'd1;
                end
            end
            S_DONE: begin
                rx_byte_d  = shift_q;
                rx_valid_d = 1'b1;
                if (rx_valid_q && !rd_data) rx_overrun_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            hcnt_q       <= 8'd0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
            div_q        <= 8'd0;
            cs_assert_q  <= 1'b0;
            rx_byte_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            sclk_q       <= sclk_d;
            mosi_q       <= mosi_d;
            div_q        <= div_d;
            cs_assert_q  <= cs_assert_d;
            rx_byte_q    <= rx_byte_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    always_comb begin
        bus.read_value_out = 32'd0;
        if (bus.sel_in) begin
            unique case (reg_sel)
                2'd0:    bus.read_value_out = {24'd0, rx_byte_q};
                2'd1:    bus.read_value_out = {28'd0, rx_overrun_q, tx_full, rx_valid_q, busy};
                2'd2:    bus.read_value_out = {23'd0, cs_assert_q, div_q};
                default: bus.read_value_out = 32'd0;
            endcase
        end
    end

    assign bus.ready_out = bus.sel_in;
    assign sclk_out      = sclk_q;
    assign mosi_out      = mosi_q;
    assign csn_out       = ~cs_assert_q;

    logic unused_bits;
    assign unused_bits = ^{bus.address_in[31:4], bus.address_in[1:0],
                           bus.write_mask_in[3:1], bus.write_value_in[31:9]};
endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: bus tasks, SPI slave model, per-scenario tasks.
module tb_spi_master;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic miso = 1'b0;
    logic sclk, mosi, csn;

    spi_master_if bus();

    spi_master dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .sclk_out (sclk),
        .mosi_out (mosi),
        .miso_in  (miso),
        .csn_out  (csn)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cyc = 0;
    always @(posedge clk) cyc++;

    // Slave model: captures MOSI on each rise, presents slave_byte MSB-first.
    logic [7:0] slave_byte = 8'h00;
    logic [7:0] mosi_cap = 8'h00;
    logic       sclk_p = 1'b0;
    int nbits = 0;
    int rise_cyc = 0;
    int fall_cyc = 0;
    int last_fall = 0;
    logic [7:0] got_q[$];
    logic [7:0] mosi_exp[$];
    logic [7:0] rx_exp[$];
    int hi_w[$];
    int lo_w[$];
    int rise_q[$];

    always @(sclk or reset or slave_byte) begin
        if (!reset) begin
            nbits = 0;
        end else if (sclk && !sclk_p) begin
            mosi_cap = {mosi_cap[6:0], mosi};
            if (nbits > 0) lo_w.push_back(cyc - fall_cyc);
            rise_cyc = cyc;
            rise_q.push_back(cyc);
            nbits++;
            if (nbits == 8) begin
                got_q.push_back(mosi_cap);
                nbits = 0;
            end
        end else if (!sclk && sclk_p) begin
            hi_w.push_back(cyc - rise_cyc);
            fall_cyc  = cyc;
            last_fall = cyc;
        end
        sclk_p = sclk;
        miso = slave_byte[3'(7 - nbits)];
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1);
    end

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.sel_in = 1'b1;
        bus.write_mask_in = 4'h1;
        bus.address_in = {16'h0006, 12'h000, a};
        bus.write_value_in = d;
        @(negedge clk);
        bus.sel_in = 1'b0;
        bus.write_mask_in = 4'h0;
        wr_cyc = cyc;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic rd, output logic [31:0] d);
        @(negedge clk);
        bus.sel_in = 1'b1;
        bus.read_in = rd;
        bus.address_in = {16'h0006, 12'h000, a};
        #1 d = bus.read_value_out;
        @(negedge clk);
        bus.sel_in = 1'b0;
        bus.read_in = 1'b0;
    endtask

    task automatic wait_idle(input int max_polls, output bit ok);
        logic [31:0] s;
        ok = 1'b0;
        for (int i = 0; i < max_polls; i++) begin
            bus_read(4'h4, 1'b0, s);
            if (!s[0]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_mon();
        hi_w.delete();
        lo_w.delete();
        rise_q.delete();
        got_q.delete();
        mosi_exp.delete();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bus.sel_in = 1'b0; bus.read_in = 1'b0; bus.write_mask_in = 4'h0;
        bus.address_in = 32'h0; bus.write_value_in = 32'h0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (csn !== 1'b1) begin errors++; $display("FAIL reset_csn: got %b want 1", csn); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", mosi); end
        checks++; if (bus.ready_out !== 1'b0 || bus.read_value_out !== 32'h0) begin
            errors++; $display("FAIL reset_unselected: got ready %b data %h want 0 0", bus.ready_out, bus.read_value_out);
        end
        bus.sel_in = 1'b1; #1;
        checks++; if (bus.ready_out !== 1'b1) begin errors++; $display("FAIL ready_sel: got %b want 1", bus.ready_out); end
        bus.sel_in = 1'b0;
        bus_read(4'h4, 1'b0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 0", d); end
        bus_read(4'h8, 1'b0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", d); end
        bus_read(4'h0, 1'b0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", d); end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        bit ok;
        int bad_hi, bad_lo, w;
        clear_mon();
        bus_write(4'h8, 32'h0000_0103);
        bus_read(4'h8, 1'b0, d);
        checks++; if (d !== 32'h103) begin errors++; $display("FAIL ctrl_readback: got %h want 103", d); end
        checks++; if (csn !== 1'b0) begin errors++; $display("FAIL csn_assert: got %b want 0", csn); end
        bus_read(4'hC, 1'b0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reg3_read: got %h want 0", d); end
        slave_byte = 8'h3C;
        rx_exp.push_back(8'h3C);
        mosi_exp.push_back(8'hA5);
        bus_write(4'h0, 32'h0000_00A5);
        w = wr_cyc;
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got busy want idle"); end
        checks++; if (rise_q.size() != 8) begin errors++; $display("FAIL basic_pulses: got %0d want 8", rise_q.size()); end
        if (rise_q.size() > 0) begin
            checks++; if (rise_q[0] - w != 5) begin errors++; $display("FAIL first_rise_latency: got %0d want 5", rise_q[0] - w); end
        end
        checks++; if (last_fall - w != 65) begin errors++; $display("FAIL byte_length: got %0d want 65", last_fall - w); end
        bad_hi = 0; bad_lo = 0;
        foreach (hi_w[i]) if (hi_w[i] != 4) bad_hi++;
        foreach (lo_w[i]) if (lo_w[i] != 4) bad_lo++;
        checks++; if (hi_w.size() != 8 || bad_hi != 0) begin errors++; $display("FAIL sclk_high: got %0d pulses %0d bad want 8 0", hi_w.size(), bad_hi); end
        checks++; if (lo_w.size() != 7 || bad_lo != 0) begin errors++; $display("FAIL sclk_low: got %0d gaps %0d bad want 7 0", lo_w.size(), bad_lo); end
        checks++; if (got_q.size() != 1 || got_q[0] !== mosi_exp[0]) begin
            errors++; $display("FAIL basic_mosi: got %0d bytes first %h want %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, mosi_exp[0]);
        end
        bus_read(4'h4, 1'b0, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL basic_status: got %h want 2", d); end
        bus_read(4'h0, 1'b1, d);
        checks++; if (d[7:0] !== rx_exp[0] || d[31:8] !== 24'h0) begin errors++; $display("FAIL basic_rx: got %h want %h", d, rx_exp[0]); end
        void'(rx_exp.pop_front());
        bus_read(4'h4, 1'b0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_valid_clear: got %h want 0", d); end
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        bit ok;
        clear_mon();
        bus_write(4'h8, 32'h0000_0100);
        slave_byte = 8'h11; rx_exp.push_back(8'h11); mosi_exp.push_back(8'h81);
        bus_write(4'h0, 32'h81);
        wait_idle(100, ok);
        slave_byte = 8'h22; rx_exp.push_back(8'h22); mosi_exp.push_back(8'h42);
        bus_write(4'h0, 32'h42);
        wait_idle(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL overrun_timeout: got busy want idle"); end
        bus_read(4'h4, 1'b0, d);
        checks++; if (d !== 32'hA) begin errors++; $display("FAIL overrun_status: got %h want a", d); end
        bus_write(4'h4, 32'h8);
        bus_read(4'h4, 1'b0, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL overrun_clear: got %h want 2", d); end
        void'(rx_exp.pop_front());
        bus_read(4'h0, 1'b1, d);
        checks++; if (d[7:0] !== rx_exp[0]) begin errors++; $display("FAIL overrun_rx: got %h want %h", d[7:0], rx_exp[0]); end
        void'(rx_exp.pop_front());
        for (int i = 0; i < 2; i++) begin
            checks++; if (got_q.size() == 0 || got_q[0] !== mosi_exp[0]) begin
                errors++; $display("FAIL overrun_mosi%0d: got %h want %h", i, (got_q.size() > 0) ? got_q[0] : 8'hxx, mosi_exp[0]);
            end
            if (got_q.size() > 0) void'(got_q.pop_front());
            void'(mosi_exp.pop_front());
        end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        bit ok;
        int w;
        clear_mon();
        slave_byte = 8'h5A; rx_exp.push_back(8'h5A);
        bus_write(4'h0, 32'h33);
        wait_idle(100, ok);
        slave_byte = 8'hC3; rx_exp.push_back(8'hC3);
        bus_write(4'h0, 32'h96);
        w = wr_cyc;
        // With div=0 the DONE edge is write edge + 18; the read strobe must sit on it.
        while (cyc < w + 16) @(negedge clk);
        bus_read(4'h0, 1'b1, d);
        checks++; if (d[7:0] !== rx_exp[0]) begin errors++; $display("FAIL collide_old: got %h want %h", d[7:0], rx_exp[0]); end
        void'(rx_exp.pop_front());
        bus_read(4'h4, 1'b0, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL collide_status: got %h want 2", d); end
        bus_read(4'h0, 1'b1, d);
        checks++; if (d[7:0] !== rx_exp[0]) begin errors++; $display("FAIL collide_new: got %h want %h", d[7:0], rx_exp[0]); end
        void'(rx_exp.pop_front());
    endtask

    task automatic test_tx_full();
        logic [31:0] d;
        bit ok;
        int n_acc, w0, bad;
`ifdef SPI_MASTER_TXFIFO_EN
        n_acc = 5;
`else
        n_acc = 2;
`endif
        clear_mon();
        slave_byte = 8'hF0;
        bus_write(4'h8, 32'h0000_01FF);
        for (int i = 0; i < 6; i++) begin
            bus_write(4'h0, 32'h10 + 32'(i));
            if (i == 0) w0 = wr_cyc;
            if (i < n_acc) mosi_exp.push_back(8'(8'h10 + i));
        end
        bus_read(4'h4, 1'b0, d);
        checks++; if (d !== 32'h5) begin errors++; $display("FAIL tx_full_status: got %h want 5", d); end
        // Shortened div must not cut the half-period already counting.
        bus_write(4'h8, 32'h0000_0100);
        wait_idle(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tx_full_timeout: got busy want idle"); end
        if (rise_q.size() > 0) begin
            checks++; if (rise_q[0] - w0 != 257) begin errors++; $display("FAIL div_reload: got %0d want 257", rise_q[0] - w0); end
        end
        checks++; if (got_q.size() != n_acc) begin errors++; $display("FAIL tx_accepted: got %0d want %0d", got_q.size(), n_acc); end
        bad = 0;
        while (got_q.size() > 0 && mosi_exp.size() > 0) begin
            if (got_q.pop_front() !== mosi_exp.pop_front()) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL tx_order: got %0d wrong bytes want 0", bad); end
        bus_read(4'h0, 1'b1, d);
        bus_write(4'h4, 32'h8);
        bus_read(4'h4, 1'b0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL tx_cleanup: got %h want 0", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bit ok;
        int n;
        clear_mon();
        bus_write(4'h8, 32'h0000_0103);
        slave_byte = 8'h77;
        bus_write(4'h0, 32'hE1);
        n = 0;
        while (rise_q.size() < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++; if (rise_q.size() < 3) begin errors++; $display("FAIL mid_rises: got %0d want 3", rise_q.size()); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL mid_sclk: got %b want 0", sclk); end
        bus.sel_in = 1'b1; bus.address_in = 32'h0006_0004; #1;
        checks++; if (bus.read_value_out !== 32'h0) begin errors++; $display("FAIL mid_status: got %h want 0", bus.read_value_out); end
        bus.sel_in = 1'b0;
        checks++; if (csn !== 1'b1) begin errors++; $display("FAIL mid_csn: got %b want 1", csn); end
        @(negedge clk);
        reset = 1'b1;
        clear_mon();
        bus_write(4'h8, 32'h0000_0101);
        slave_byte = 8'h9D; rx_exp.push_back(8'h9D); mosi_exp.push_back(8'h5B);
        bus_write(4'h0, 32'h5B);
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_timeout: got busy want idle"); end
        checks++; if (got_q.size() != 1 || got_q[0] !== mosi_exp[0]) begin
            errors++; $display("FAIL mid_mosi: got %0d bytes first %h want %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, mosi_exp[0]);
        end
        bus_read(4'h0, 1'b1, d);
        checks++; if (d[7:0] !== rx_exp[0]) begin errors++; $display("FAIL mid_rx: got %h want %h", d[7:0], rx_exp[0]); end
        void'(rx_exp.pop_front());
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_collision();
        test_tx_full();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
